// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 2D DCT controller: FSM states, lane count
// and lane packing helper.
package dct_pkg;

    localparam int unsigned LANES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_RDRAIN,
        ST_CISSUE,
        ST_CWAIT,
        ST_COUT
    } state_e;

    // LSB position of lane k in a packed row/column of w-bit samples.
    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/dct2d_ctrl_if.sv
// Row-in / column-out handshake bundle of the 2D DCT controller.
interface dct2d_ctrl_if #(
    parameter int unsigned DATA_W = 12
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [8*DATA_W-1:0]   in_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*DATA_W-1:0]   out_col;
    logic                  out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_col, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_col, out_last
    );

endinterface

// File: rtl/dct_tbuf.sv
// 8x8 transpose buffer: whole-row write, whole-column combinational read.
module dct_tbuf
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [2:0]                wr_row_i,
    input  logic [LANES*DATA_W-1:0]   wr_data_i,
    input  logic [2:0]                rd_col_i,
    output logic [LANES*DATA_W-1:0]   rd_data_o
);

    logic [DATA_W-1:0] mem_q [LANES][LANES];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                mem_q[wr_row_i][3'(k)] <= wr_data_i[lane_lsb(k, DATA_W) +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            rd_data_o[lane_lsb(k, DATA_W) +: DATA_W] = mem_q[3'(k)][rd_col_i];
        end
    end

endmodule

// File: rtl/dct2d_ctrl.sv
// 2D 8x8 DCT controller time-sharing one 1D core over a row pass and a column pass.
// Optional block counter output enabled by defining DCT2D_CTRL_BLKCNT_EN.
module dct2d_ctrl
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned DCT_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    dct2d_ctrl_if.slave               bus,
    output logic [LANES*DATA_W-1:0]   dct_a,
    input  logic [LANES*DATA_W-1:0]   dct_b,
    output logic                      busy
`ifdef DCT2D_CTRL_BLKCNT_EN
    ,
    output logic [15:0]               blk_count
`endif
);

    localparam int unsigned DEPTH  = DCT_LAT + 1;
    localparam int unsigned WCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ROW_W  = LANES * DATA_W;

    state_e              state_q, state_d;
    logic [2:0]          r_q, r_d;
    logic [2:0]          c_q, c_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ROW_W-1:0]    dct_a_q, dct_a_d;
    logic [ROW_W-1:0]    out_col_q, out_col_d;
    logic [DEPTH-1:0]    cap_v_q;
    logic [2:0]          cap_idx_q [DEPTH];

    logic                in_hs;
    logic                out_hs;
    logic                cap_we;
    logic [2:0]          cap_row;
    logic [ROW_W-1:0]    col_rd;

    assign in_hs   = bus.in_valid && (state_q == ST_ROW);
    assign out_hs  = bus.out_ready && (state_q == ST_COUT);
    assign cap_we  = cap_v_q[DEPTH-1];
    assign cap_row = cap_idx_q[DEPTH-1];

    dct_tbuf #(
        .DATA_W (DATA_W)
    ) u_tbuf (
        .clk       (clk),
        .wr_en_i   (cap_we),
        .wr_row_i  (cap_row),
        .wr_data_i (dct_b),
        .rd_col_i  (c_q),
        .rd_data_o (col_rd)
    );

    // Row index rides alongside the core latency so the result lands in its own tbuf row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cap_idx_q[i] <= '0;
            end
        end else begin
            cap_v_q[0]   <= in_hs;
            cap_idx_q[0] <= r_q;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                cap_v_q[i]   <= cap_v_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            wcnt_q    <= '0;
            dct_a_q   <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            wcnt_q    <= wcnt_d;
            dct_a_q   <= dct_a_d;
            out_col_q <= out_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        wcnt_d    = wcnt_q;
        dct_a_d   = dct_a_q;
        out_col_d = out_col_q;
        case (state_q)
            ST_IDLE: state_d = ST_ROW;
            ST_ROW: begin
                if (in_hs) begin
                    dct_a_d = bus.in_row;
                    r_d     = r_q + 3'd1;
                    if (r_q == 3'd7) state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                if (cap_we && (cap_row == 3'd7)) state_d = ST_CISSUE;
            end
            ST_CISSUE: begin
                dct_a_d = col_rd;
                wcnt_d  = '0;
                state_d = ST_CWAIT;
            end
            ST_CWAIT: begin
                if (wcnt_q == WCNT_W'(DCT_LAT)) begin
                    out_col_d = dct_b;
                    state_d   = ST_COUT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_COUT: begin
                if (out_hs) begin
                    c_d     = c_q + 3'd1;
                    state_d = (c_q == 3'd7) ? ST_ROW : ST_CISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_ROW);
    assign bus.out_valid = (state_q == ST_COUT);
    assign bus.out_last  = (state_q == ST_COUT) && (c_q == 3'd7);
    assign bus.out_col   = out_col_q;
    assign dct_a         = dct_a_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef DCT2D_CTRL_BLKCNT_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_q <= '0;
        end else if (out_hs && (c_q == 3'd7)) begin
            blk_count_q <= blk_count_q + 16'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: doc/dct2d_ctrl.md
DCT2D_CTRL -- requirements
Module: dct2d_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample/coefficient width per lane.
REQ-002 SHALL have parameter DCT_LAT, default 1, clock cycles from core input change to registered core output.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, in_row carries one image row.
REQ-006 SHALL have port in_ready, output, 1, controller accepts a row this cycle.
REQ-007 SHALL have port in_row, input, 8*DATA_W, 8 signed samples; lane k at bits [k*DATA_W+DATA_W-1 : k*DATA_W].
REQ-008 SHALL have port dct_a, output, 8*DATA_W, registered operand to the 8-point 1D DCT core (lane k -> core input a_k).
REQ-009 SHALL have port dct_b, input, 8*DATA_W, core result (lane k <- core output b_k).
REQ-010 SHALL have port out_valid, output, 1, out_col holds a finished column.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_col.
REQ-012 SHALL have port out_col, output, 8*DATA_W, 2D coefficients of one column; same lane packing.
REQ-013 SHALL have port out_last, output, 1, high with out_valid on column 7.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL time-share one 1D DCT core across a row pass (8 rows) then a column pass (8 columns) per 8x8 block, with no block overlap.
REQ-016 SHALL implement states IDLE, ROW, RDRAIN, CISSUE, CWAIT, COUT.
REQ-017 IDLE SHALL go to ROW unconditionally the cycle after reset release; after the block ends, COUT returns to ROW directly.
REQ-018 In ROW, in_ready SHALL be 1; a handshake (in_valid&in_ready) loads in_row into dct_a at that edge (issue edge) and increments the 3-bit row counter r.
REQ-019 The core result of each issued row SHALL be written to transpose buffer row r at issue edge + DCT_LAT + 1, tracked by a DCT_LAT+1 deep valid/index shift pipeline.
REQ-020 in_valid low in ROW SHALL stall: counter holds, dct_a holds, pending captures still complete.
REQ-021 Handshake with r=7 SHALL go to RDRAIN; in_ready is 0 in every state except ROW; in_valid outside ROW is ignored.
REQ-022 RDRAIN SHALL exit to CISSUE on the edge where the row-7 capture occurs.
REQ-023 CISSUE SHALL load dct_a lane k with tbuf[k][c] (column counter c) and go to CWAIT for DCT_LAT+1 cycles.
REQ-024 On CWAIT exit, dct_b SHALL be registered into out_col and state goes to COUT with out_valid=1.
REQ-025 In COUT, out_col/out_valid/out_last SHALL hold stable while out_ready=0; on handshake out_valid drops next cycle, c increments, and state goes to CISSUE (c<7) or ROW (c=7, counter wraps to 0).
REQ-026 Controller SHALL not modify data: widths pass through unchanged, no rounding or saturation (overflow wraps, owned by the core).

Reset
REQ-027 rst SHALL force IDLE, r=0, c=0, capture pipeline cleared, in_ready=0, out_valid=0, out_last=0, busy=0, dct_a=0, out_col=0; tbuf contents need not be cleared.
REQ-028 rst mid-block SHALL abandon the block; no partial column is emitted afterward.

Configuration
REQ-029 With DCT2D_CTRL_BLKCNT_EN defined, SHALL add output blk_count (16 bits, reset 0) incrementing on each out_last handshake, wrapping 0xFFFF->0; without it, port and counter SHALL not exist.

Structure
REQ-030 State encoding, lane count (8) and lane pack/unpack helpers SHALL reside in shared package dct_pkg.
REQ-031 Transpose buffer SHALL be sub-module dct_tbuf (8x8xDATA_W, row write, column read).

Verification (core instantiated with default constants)
REQ-032 All-zero block, out_ready=1 -> eight columns, all lanes 0, out_last only on the eighth.
REQ-033 All samples 50 -> column 0 lane0=398, other lanes 0; columns 1-7 all 0.
REQ-034 out_ready held 0 for 10 cycles on column 3 -> out_col unchanged, out_valid stays 1, no column skipped or repeated.
REQ-035 in_valid toggled every other cycle in ROW -> identical output to REQ-033 case.
REQ-036 rst asserted after row 4 accepted, then full all-50 block -> only that block's 8 columns appear, values per REQ-033.
REQ-037 With DCT2D_CTRL_BLKCNT_EN, three consecutive blocks -> blk_count=3.
